morse_blink_sequencer: RTL

- Plays one Morse character at a time on an LED output, using standard Morse unit timing.
- Sits between the ASCII→Morse encoder and the board LED pin. It takes the encoder's pattern, length and valid outputs under a start/ready handshake.
- Pulses done after the trailing letter gap, so an upstream message FSM can feed the next character.

---
 rtl/morse_pkg.sv | 26 ++
 rtl/morse_unit_timer.sv | 34 +++
 rtl/morse_blink_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared state type and Morse timing constants for the blink sequencer.
// The WRD_GAP state exists only when MORSE_WORD_GAP_EN is defined.
package morse_pkg;

    localparam int MORSE_PAT_W = 5;
    localparam int MORSE_LEN_W = 3;
    localparam int UNITS_W     = 3;
    localparam int MAX_UNITS   = 7;

    localparam logic [UNITS_W-1:0] DOT_UNITS     = 3'd1;
    localparam logic [UNITS_W-1:0] DASH_UNITS    = 3'd3;
    localparam logic [UNITS_W-1:0] SYM_GAP_UNITS = 3'd1;
    localparam logic [UNITS_W-1:0] LTR_GAP_UNITS = 3'd3;
    localparam logic [UNITS_W-1:0] WRD_GAP_UNITS = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYM_GAP,
        LTR_GAP
`ifdef MORSE_WORD_GAP_EN
        , WRD_GAP
`endif
    } morse_state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring whole Morse units; expired is high while
// the count reads 0, which is the last cycle of the loaded duration.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 2_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [UNITS_W-1:0] units,
    output logic               expired
);

    localparam int               CNT_W = $clog2(MAX_UNITS * CLKS_PER_UNIT);
    localparam logic [CNT_W-1:0] CLKS  = CNT_W'(CLKS_PER_UNIT);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] load_val;

    assign load_val = CNT_W'(units) * CLKS - CNT_W'(1);
    assign expired  = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_blink_sequencer.sv
// Plays one Morse character on the LED with standard unit timing and pulses
// o_Done after the letter gap. Define MORSE_WORD_GAP_EN to turn invalid starts into a 7-unit word gap.
module morse_blink_sequencer
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 2_500_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Start,
    input  logic [MORSE_PAT_W-1:0] i_Morse_Pattern,
    input  logic [MORSE_LEN_W-1:0] i_Morse_Length,
    input  logic                   i_Valid,
    input  logic                   i_Abort,
    output logic                   o_Ready,
    output logic                   o_LED,
    output logic                   o_Done
);

    morse_state_t           state;
    morse_state_t           next_state;
    logic [MORSE_PAT_W-1:0] pattern;
    logic [MORSE_LEN_W-1:0] sym_left;
    logic                   char_ok;
    logic                   accept;
    logic                   advance;
    logic                   timer_load;
    logic                   timer_expired;
    logic [UNITS_W-1:0]     timer_units;

    function automatic logic [UNITS_W-1:0] mark_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

    assign char_ok = i_Valid && (i_Morse_Length != '0) && (i_Morse_Length <= 3'd5);
    assign o_Ready = (state == IDLE);

    morse_unit_timer #(
        .CLKS_PER_UNIT (CLKS_PER_UNIT)
    ) u_timer (
        .clk     (i_Clk),
        .rst_n   (i_Rst_n),
        .load    (timer_load),
        .units   (timer_units),
        .expired (timer_expired)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every state entry reloads the timer, so states chain with no bubble cycles.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_units = DOT_UNITS;
        accept      = 1'b0;
        advance     = 1'b0;
        o_Done      = 1'b0;
        if (state != IDLE && i_Abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Start && !i_Abort) begin
                        if (char_ok) begin
                            accept      = 1'b1;
                            timer_load  = 1'b1;
                            timer_units = mark_units(i_Morse_Pattern[MORSE_PAT_W-1]);
                            next_state  = MARK;
                        end
`ifdef MORSE_WORD_GAP_EN
                        else begin
                            timer_load  = 1'b1;
                            timer_units = WRD_GAP_UNITS;
                            next_state  = WRD_GAP;
                        end
`endif
                    end
                end
                MARK: begin
                    if (timer_expired) begin
                        timer_load = 1'b1;
                        if (sym_left > 3'd1) begin
                            timer_units = SYM_GAP_UNITS;
                            next_state  = SYM_GAP;
                        end else begin
                            timer_units = LTR_GAP_UNITS;
                            next_state  = LTR_GAP;
                        end
                    end
                end
                SYM_GAP: begin
                    if (timer_expired) begin
                        // The next symbol is still one bit below the MSB until the shift lands.
                        timer_load  = 1'b1;
                        timer_units = mark_units(pattern[MORSE_PAT_W-2]);
                        advance     = 1'b1;
                        next_state  = MARK;
                    end
                end
                LTR_GAP: begin
                    if (timer_expired) begin
                        o_Done     = 1'b1;
                        next_state = IDLE;
                    end
                end
`ifdef MORSE_WORD_GAP_EN
                WRD_GAP: begin
                    if (timer_expired) begin
                        o_Done     = 1'b1;
                        next_state = IDLE;
                    end
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pattern  <= '0;
            sym_left <= '0;
            o_LED    <= 1'b0;
        end else begin
            o_LED <= (next_state == MARK);
            if (accept) begin
                pattern  <= i_Morse_Pattern;
                sym_left <= i_Morse_Length;
            end else if (advance) begin
                pattern  <= {pattern[MORSE_PAT_W-2:0], 1'b0};
                sym_left <= sym_left - MORSE_LEN_W'(1);
            end
        end
    end

endmodule
